// File: rtl/mpu_i2c_pkg.sv
// Shared types and register addresses for the MPU-6050 emulating I2C target.
package mpu_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic [7:0] REG_GX_H       = 8'h43;
    localparam logic [7:0] REG_PWR_MGMT_1 = 8'h6B;
    localparam logic [7:0] REG_WHO_AM_I   = 8'h75;

    // Byte idx of the {gx, gy, gz} snapshot, big-endian (idx 0 = GX_H).
    function automatic logic [7:0] snap_byte(input logic [47:0] snap, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = snap[47:40];
            3'd1:    b = snap[39:32];
            3'd2:    b = snap[31:24];
            3'd3:    b = snap[23:16];
            3'd4:    b = snap[15:8];
            3'd5:    b = snap[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mpu_i2c_target_if.sv
// I2C pad-side signals of the target: raw SCL/SDA in, open-drain SDA enable out.
interface mpu_i2c_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe_out;

    modport slave  (input scl_in, input sda_in, output sda_oe_out);
    modport master (output scl_in, output sda_in, input sda_oe_out);
endinterface

// File: rtl/i2c_bus_cond.sv
// Synchronizes raw SCL/SDA and derives SCL edges plus START/STOP pulses.
module i2c_bus_cond (
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // bit 1 = SCL, bit 0 = SDA; reset to the idle (released) bus level
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic [1:0] r_prev;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_meta <= 2'b11;
            r_sync <= 2'b11;
            r_prev <= 2'b11;
        end else begin
            r_meta <= {i_scl, i_sda};
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sda      = r_sync[0];
    assign o_scl_rise =  r_sync[1] & ~r_prev[1];
    assign o_scl_fall = ~r_sync[1] &  r_prev[1];
    assign o_start    =  r_sync[1] &  r_prev[1] &  r_prev[0] & ~r_sync[0];
    assign o_stop     =  r_sync[1] &  r_prev[1] & ~r_prev[0] &  r_sync[0];

endmodule

// File: rtl/mpu_i2c_target.sv
// I2C target answering the MPU-6050 gyro/PWR_MGMT_1/WHO_AM_I subset, gyro data from ports.
module mpu_i2c_target
    import mpu_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter logic [7:0] WHOAMI_VAL  = 8'h68,
    parameter logic [7:0] PWR_RST_VAL = 8'h40
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mpu_i2c_target_if.slave     bus,
    input  logic signed [15:0]  gx_in,
    input  logic signed [15:0]  gy_in,
    input  logic signed [15:0]  gz_in,
    output logic [7:0]          pwr_mgmt_out,
    output logic                wr_valid_out,
    output logic [7:0]          wr_addr_out,
    output logic [7:0]          wr_data_out,
    output logic                busy_out
);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_cond u_bus_cond (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_scl      (bus.scl_in),
        .i_sda      (bus.sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_tgt_state_t r_state, w_state_next;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift, r_reg_ptr, r_pwr, r_wr_addr, r_wr_data;
    logic        r_wr_valid, r_rw, r_busy, r_sda_oe;
    logic [47:0] r_snap;
    logic        w_sda_oe_next, w_busy_next, w_wr_pulse, w_addr_hit;
    logic [2:0]  w_tx_idx;
    logic [7:0]  w_tx_byte, w_gyro_off;

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Phases advance on SCL fall so SDA only moves while SCL is low.
    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = ST_ADDR;
        end else if (w_stop) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_ADDR:     if (w_scl_fall && r_bit_cnt == 4'd8)
                                 w_state_next = (r_shift[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: if (w_scl_fall && r_bit_cnt != 4'd0)
                                 w_state_next = r_rw ? ST_RDATA : ST_PTR;
                ST_PTR:      if (w_scl_fall && r_bit_cnt == 4'd8) w_state_next = ST_PTR_ACK;
                ST_PTR_ACK:  if (w_scl_fall && r_bit_cnt != 4'd0) w_state_next = ST_WDATA;
                ST_WDATA:    if (w_scl_fall && r_bit_cnt == 4'd8) w_state_next = ST_WACK;
                ST_WACK:     if (w_scl_fall && r_bit_cnt != 4'd0) w_state_next = ST_WDATA;
                ST_RDATA:    if (w_scl_fall && r_bit_cnt == 4'd8) w_state_next = ST_RACK;
                ST_RACK: begin
                    if (w_scl_rise && w_sda)                      w_state_next = ST_IGNORE;
                    else if (w_scl_fall && r_bit_cnt != 4'd0)     w_state_next = ST_RDATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_sda_oe_next = r_sda_oe;
        w_busy_next   = r_busy;
        w_addr_hit    = (r_state == ST_ADDR) && (w_state_next == ST_ADDR_ACK);
        w_wr_pulse    = (r_state == ST_WDATA) && (w_state_next == ST_WACK);
        w_tx_idx      = (r_state == ST_RDATA) ? ~r_bit_cnt[2:0] : 3'd7;
        if (w_start || w_stop) begin
            w_sda_oe_next = 1'b0;
        end else if (w_scl_fall) begin
            case (w_state_next)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WACK: w_sda_oe_next = 1'b1;
                ST_RDATA:                         w_sda_oe_next = ~w_tx_byte[w_tx_idx];
                default:                          w_sda_oe_next = 1'b0;
            endcase
        end
        if (w_stop)          w_busy_next = 1'b0;
        else if (w_addr_hit) w_busy_next = 1'b1;
    end

    assign w_gyro_off = r_reg_ptr - REG_GX_H;

    always_comb begin
        w_tx_byte = 8'h00;
        if (w_gyro_off < 8'd6)                 w_tx_byte = snap_byte(r_snap, w_gyro_off[2:0]);
        else if (r_reg_ptr == REG_PWR_MGMT_1)  w_tx_byte = r_pwr;
        else if (r_reg_ptr == REG_WHO_AM_I)    w_tx_byte = WHOAMI_VAL;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_reg_ptr  <= '0;
            r_pwr      <= PWR_RST_VAL;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_valid <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_snap     <= '0;
        end else begin
            r_sda_oe   <= w_sda_oe_next;
            r_busy     <= w_busy_next;
            r_wr_valid <= w_wr_pulse;
            if (w_start || (w_state_next != r_state))
                r_bit_cnt <= '0;
            else if (w_scl_rise && r_bit_cnt != 4'd8)
                r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_scl_rise)
                r_shift <= {r_shift[6:0], w_sda};
            // Gyro words are captured together so a burst read never tears.
            if (w_addr_hit) begin
                r_rw <= r_shift[0];
                if (r_shift[0])
                    r_snap <= {gx_in, gy_in, gz_in};
            end
            if (r_state == ST_PTR && w_state_next == ST_PTR_ACK)
                r_reg_ptr <= r_shift;
            else if ((r_state == ST_WACK && w_state_next == ST_WDATA) ||
                     (r_state == ST_RACK && w_state_next == ST_RACK && w_scl_rise))
                r_reg_ptr <= r_reg_ptr + 8'd1;
            if (w_wr_pulse) begin
                r_wr_addr <= r_reg_ptr;
                r_wr_data <= r_shift;
                if (r_reg_ptr == REG_PWR_MGMT_1)
                    r_pwr <= r_shift;
            end
        end
    end

    assign bus.sda_oe_out = r_sda_oe;
    assign pwr_mgmt_out   = r_pwr;
    assign wr_valid_out   = r_wr_valid;
    assign wr_addr_out    = r_wr_addr;
    assign wr_data_out    = r_wr_data;
    assign busy_out       = r_busy;

endmodule

// File: tb/tb_mpu_i2c_target.sv
// Bit-banged I2C master driving mpu_i2c_target, checked against a register-level model.
`timescale 1ns/1ps
module tb_mpu_i2c_target;

    localparam int Q = 50;            // quarter SCL period: SCL = 20 clk cycles
    localparam logic [6:0] DEV = 7'h68;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic m_scl = 1'b1, m_sda = 1'b1;
    logic signed [15:0] gx_in = '0, gy_in = '0, gz_in = '0;
    logic [7:0] pwr_mgmt_out, wr_addr_out, wr_data_out;
    logic wr_valid_out, busy_out;

    int vectors = 0;
    int errors  = 0;

    // behavioural model
    logic [7:0]  m_pwr = 8'h40;
    logic [15:0] m_gx, m_gy, m_gz;
    logic [7:0]  q_waddr[$], q_wdata[$];
    logic [7:0]  tx_buf[16], rx_buf[16];
    bit          quiet_en = 0;
    logic        prev_oe = 1'b0, prev_scl = 1'b1;

    mpu_i2c_target_if bus();
    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe_out;   // open-drain wired-AND

    always #5 clk_in = ~clk_in;

    mpu_i2c_target #(.DEV_ADDR(7'h68), .WHOAMI_VAL(8'h68), .PWR_RST_VAL(8'h40)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (bus),
        .gx_in        (gx_in),
        .gy_in        (gy_in),
        .gz_in        (gz_in),
        .pwr_mgmt_out (pwr_mgmt_out),
        .wr_valid_out (wr_valid_out),
        .wr_addr_out  (wr_addr_out),
        .wr_data_out  (wr_data_out),
        .busy_out     (busy_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_reg(input logic [7:0] p);
        case (p)
            8'h43:   return m_gx[15:8];
            8'h44:   return m_gx[7:0];
            8'h45:   return m_gy[15:8];
            8'h46:   return m_gy[7:0];
            8'h47:   return m_gz[15:8];
            8'h48:   return m_gz[7:0];
            8'h6B:   return m_pwr;
            8'h75:   return 8'h68;
            default: return 8'h00;
        endcase
    endfunction

    // Per-cycle compare: write pulses, SDA never moves while SCL is high, quiet bus when not addressed.
    always @(negedge clk_in) begin
        if (wr_valid_out) begin
            if (q_waddr.size() == 0) begin
                check("wr_unexpected", 32'(wr_addr_out), 32'hFFFF);
            end else begin
                check("wr_addr", wr_addr_out, q_waddr.pop_front());
                check("wr_data", wr_data_out, q_wdata.pop_front());
            end
        end
        if (!rst_in && m_scl && prev_scl)
            check("oe_stable_scl_high", bus.sda_oe_out, prev_oe);
        if (quiet_en) begin
            check("ignore_oe", bus.sda_oe_out, 1'b0);
            check("ignore_busy", busy_out, 1'b0);
        end
        prev_oe  = bus.sda_oe_out;
        prev_scl = m_scl;
    end

    task automatic start_c();
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic stop_c();
        m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic wbit(input logic b);
        m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = bus.sda_in; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack_n);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
    endtask

    task automatic finish_txn();
        #(4*Q);
        check("busy_after_stop", busy_out, 1'b0);
        check("pwr_mgmt", pwr_mgmt_out, m_pwr);
        check("wr_pending", q_waddr.size(), 0);
    endtask

    task automatic do_write(input logic [7:0] ptr, input int n);
        logic a;
        $display("txn write ptr=%02h n=%0d", ptr, n);
        start_c();
        wbyte({DEV, 1'b0}, a); check("wr_addr_ack", a, 1'b0);
        check("wr_busy", busy_out, 1'b1);
        wbyte(ptr, a);         check("wr_ptr_ack", a, 1'b0);
        for (int i = 0; i < n; i++) begin
            q_waddr.push_back(8'(ptr + 8'(i)));
            q_wdata.push_back(tx_buf[i]);
            if (8'(ptr + 8'(i)) == 8'h6B) m_pwr = tx_buf[i];
            wbyte(tx_buf[i], a); check("wr_data_ack", a, 1'b0);
        end
        stop_c();
        finish_txn();
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n, input bit chg, input logic [15:0] new_gx);
        logic a;
        logic [7:0] d;
        $display("txn read ptr=%02h n=%0d", ptr, n);
        start_c();
        wbyte({DEV, 1'b0}, a); check("rd_addr_w_ack", a, 1'b0);
        wbyte(ptr, a);         check("rd_ptr_ack", a, 1'b0);
        start_c();
        m_gx = gx_in; m_gy = gy_in; m_gz = gz_in;
        wbyte({DEV, 1'b1}, a); check("rd_addr_r_ack", a, 1'b0);
        check("rd_busy", busy_out, 1'b1);
        for (int i = 0; i < n; i++) begin
            rbyte(d, (i == n - 1));
            rx_buf[i] = d;
            check("rd_data", d, model_reg(8'(ptr + 8'(i))));
            if (chg && i == 0) gx_in = new_gx;
        end
        stop_c();
        finish_txn();
    endtask

    task automatic do_bad_addr(input logic [6:0] addr, input logic rw);
        logic a;
        $display("txn bad address %02h rw=%0d", addr, rw);
        quiet_en = 1;
        start_c();
        wbyte({addr, rw}, a);  check("bad_addr_nack", a, 1'b1);
        wbyte(8'h00, a);       check("bad_byte_nack", a, 1'b1);
        stop_c();
        #(4*Q);
        quiet_en = 0;
        check("bad_pwr_mgmt", pwr_mgmt_out, m_pwr);
    endtask

    logic [7:0] lit6[6];
    logic       a_tmp;

    initial begin
        lit6 = '{8'h12, 8'h34, 8'hFF, 8'h01, 8'h80, 8'h00};
        #3;
        #40 rst_in = 1'b0;
        #10;
        $display("txn reset");
        check("rst_oe", bus.sda_oe_out, 1'b0);
        check("rst_pwr", pwr_mgmt_out, 8'h40);
        check("rst_wr_valid", wr_valid_out, 1'b0);
        check("rst_wr_addr", wr_addr_out, 8'h00);
        check("rst_wr_data", wr_data_out, 8'h00);
        check("rst_busy", busy_out, 1'b0);

        tx_buf[0] = 8'h00;
        do_write(8'h6B, 1);
        check("lit_pwr_cleared", pwr_mgmt_out, 8'h00);

        gx_in = 16'h1234; gy_in = 16'hFF01; gz_in = 16'h8000;
        do_read(8'h43, 6, 1'b1, 16'hAAAA);
        for (int i = 0; i < 6; i++) check("lit_gyro_burst", rx_buf[i], lit6[i]);
        do_read(8'h43, 2, 1'b0, 16'h0000);
        check("lit_gx_h_new", rx_buf[0], 8'hAA);
        check("lit_gx_l_new", rx_buf[1], 8'hAA);

        do_read(8'h75, 1, 1'b0, 16'h0000);
        check("lit_whoami", rx_buf[0], 8'h68);
        do_read(8'hFF, 2, 1'b0, 16'h0000);
        check("lit_wrap_ff", rx_buf[0], 8'h00);
        check("lit_wrap_00", rx_buf[1], 8'h00);

        do_bad_addr(7'h69, 1'b0);

        // reset while the target drives a 0 data bit
        $display("txn reset during read");
        start_c();
        wbyte({DEV, 1'b0}, a_tmp); check("mr_addr_ack", a_tmp, 1'b0);
        wbyte(8'h00, a_tmp);       check("mr_ptr_ack", a_tmp, 1'b0);
        start_c();
        wbyte({DEV, 1'b1}, a_tmp); check("mr_addr_r_ack", a_tmp, 1'b0);
        check("mr_driving", bus.sda_oe_out, 1'b1);
        rst_in = 1'b1;
        #10 rst_in = 1'b0;
        m_pwr = 8'h40;
        check("mr_oe_released", bus.sda_oe_out, 1'b0);
        check("mr_busy", busy_out, 1'b0);
        check("mr_pwr_reset", pwr_mgmt_out, 8'h40);
        stop_c();
        #(2*Q);
        tx_buf[0] = 8'h07;
        do_write(8'h6B, 1);
        check("lit_pwr_after_rst", pwr_mgmt_out, 8'h07);

        for (int t = 0; t < 20; t++) begin
            logic [7:0] p;
            logic [6:0] ba;
            int n;
            gx_in = 16'($urandom); gy_in = 16'($urandom); gz_in = 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    p = ($urandom_range(0, 1) == 1) ? 8'h6B : 8'($urandom);
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
                    do_write(p, n);
                end
                1, 2: begin
                    case ($urandom_range(0, 3))
                        0:       p = 8'(8'h43 + 8'($urandom_range(0, 5)));
                        1:       p = 8'h6B;
                        2:       p = 8'h75;
                        default: p = 8'($urandom);
                    endcase
                    n = $urandom_range(1, 4);
                    do_read(p, n, ($urandom_range(0, 1) == 1), 16'($urandom));
                end
                default: begin
                    ba = 7'($urandom_range(0, 127));
                    if (ba == DEV) ba = 7'h69;
                    do_bad_addr(ba, 1'($urandom_range(0, 1)));
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
